// File: rtl/uart_cmd_link.sv
// Full-duplex UART with acquisition-config packet decoder.
// RX framing checks, false-start rejection and timeout; TX of TX_BYTES-wide words.
module uart_cmd_link #(
    parameter int CLK_HZ          = 60_000_000,
    parameter int BAUD            = 921600,
    parameter int TX_BYTES        = 2,
    parameter int RX_TIMEOUT_BITS = 20
) (
    input  logic                  clk_PSRAM,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    input  logic                  send_uart,
    input  logic [8*TX_BYTES-1:0] send_msg,
    output logic                  tx_busy,
    output logic                  flag_end_tx,
    output logic [7:0]            trigger,
    output logic [12:0]           threshold,
    output logic [23:0]           samples_after,
    output logic [23:0]           samples_before,
    output logic                  flag_acq,
    output logic                  flag_debug,
    output logic                  rx_error
);

    localparam int DIV     = CLK_HZ / BAUD;
    localparam int CW      = $clog2(DIV);
    localparam int TMO_CYC = RX_TIMEOUT_BITS * DIV;
    localparam int TW      = $clog2(TMO_CYC + 1);
    localparam int PW      = $clog2(10);
    localparam int BW      = $clog2(TX_BYTES + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);
    localparam logic [BW-1:0] TX_LAST   = BW'(TX_BYTES - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic       {P_HEAD, P_COLLECT} p_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ------------------------------------------------------------------ RX
    logic            rx_s1, rx_s2, rx_prev;
    logic            rx_fall;
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic            rx_tick;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_done, rx_ferr, rx_valid;

    // Synchroniser resets to the idle-high level so reset release never looks like a start edge.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_tick = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        rx_done = 1'b0;
        rx_ferr = 1'b0;
        unique case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_s2) begin
                        rx_next = RX_IDLE;
                        rx_done = 1'b1;
                    end else begin
                        rx_next = RX_WAIT;
                        rx_ferr = 1'b1;
                    end
                end
            end
            RX_WAIT:  if (rx_s2) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= rx_done;
            if (rx_state != rx_next || rx_tick || rx_state == RX_IDLE || rx_state == RX_WAIT)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START) begin
                rx_bit <= '0;
            end else if (rx_state == RX_DATA && rx_tick) begin
                rx_bit   <= rx_bit + 1'b1;
                rx_shift <= {rx_s2, rx_shift[7:1]};
            end
        end
    end

    // -------------------------------------------------------------- parser
    p_state_t        p_state, p_next;
    logic [PW-1:0]   p_cnt;
    logic [TW-1:0]   rx_timer;
    logic            dbg_hit, pkt_done, tmo_hit;
    logic [7:0]      stage_trig;
    logic [12:0]     stage_thr;
    logic [23:0]     stage_after;
    logic [15:0]     stage_before;

    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) p_state <= P_HEAD;
        else        p_state <= p_next;
    end

    always_comb begin
        p_next   = p_state;
        dbg_hit  = 1'b0;
        pkt_done = 1'b0;
        tmo_hit  = 1'b0;
        if (rx_ferr) begin
            p_next = P_HEAD;
        end else begin
            unique case (p_state)
                P_HEAD: begin
                    if (rx_valid) begin
                        if (rx_shift == 8'h53)      dbg_hit = 1'b1;
                        else if (rx_shift == 8'h41) p_next  = P_COLLECT;
                    end
                end
                P_COLLECT: begin
                    if (rx_valid) begin
                        if (p_cnt == PW'(9)) begin
                            pkt_done = 1'b1;
                            p_next   = P_HEAD;
                        end
                    end else if (rx_timer == TMO_LAST) begin
                        tmo_hit = 1'b1;
                        p_next  = P_HEAD;
                    end
                end
                default: p_next = P_HEAD;
            endcase
        end
    end

    // Timer idles at zero except between a stop sample and the next start inside a packet.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            p_cnt        <= PW'(1);
            rx_timer     <= '0;
            stage_trig   <= '0;
            stage_thr    <= '0;
            stage_after  <= '0;
            stage_before <= '0;
        end else begin
            if (p_state == P_HEAD) p_cnt <= PW'(1);
            else if (rx_valid)     p_cnt <= p_cnt + 1'b1;

            if (p_state == P_COLLECT && rx_state == RX_IDLE) rx_timer <= rx_timer + 1'b1;
            else                                             rx_timer <= '0;

            if (p_state == P_COLLECT && rx_valid) begin
                case (p_cnt)
                    PW'(1): stage_trig          <= rx_shift;
                    PW'(2): stage_thr[12:8]     <= rx_shift[4:0];
                    PW'(3): stage_thr[7:0]      <= rx_shift;
                    PW'(4): stage_after[23:16]  <= rx_shift;
                    PW'(5): stage_after[15:8]   <= rx_shift;
                    PW'(6): stage_after[7:0]    <= rx_shift;
                    PW'(7): stage_before[15:8]  <= rx_shift;
                    PW'(8): stage_before[7:0]   <= rx_shift;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            trigger        <= '0;
            threshold      <= '0;
            samples_after  <= '0;
            samples_before <= '0;
            flag_acq       <= 1'b0;
            flag_debug     <= 1'b0;
            rx_error       <= 1'b0;
        end else begin
            flag_acq   <= pkt_done;
            flag_debug <= dbg_hit;
            rx_error   <= rx_ferr | tmo_hit;
            if (pkt_done) begin
                trigger        <= stage_trig;
                threshold      <= stage_thr;
                samples_after  <= stage_after;
                samples_before <= {stage_before, rx_shift};
            end
        end
    end

    // ------------------------------------------------------------------ TX
    tx_state_t             tx_state, tx_next;
    logic [CW-1:0]         tx_cnt;
    logic                  tx_tick;
    logic [2:0]            tx_bit;
    logic [BW-1:0]         tx_nbyte;
    logic [8*TX_BYTES-1:0] tx_msg;
    logic [7:0]            tx_cur;
    logic                  tx_line, tx_last;

    assign tx_tick = (tx_cnt == BIT_LAST);
    assign tx_cur  = tx_msg[8*TX_BYTES-1 -: 8];
    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_last = 1'b0;
        tx_line = 1'b1;
        unique case (tx_state)
            TX_IDLE:  if (send_uart) tx_next = TX_START;
            TX_START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_cur[tx_bit];
                if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_nbyte == TX_LAST) begin
                        tx_next = TX_IDLE;
                        tx_last = 1'b1;
                    end else begin
                        tx_next = TX_START;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Line is registered for a glitch-free output; the async reset still forces it high at once.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx     <= 1'b1;
            flag_end_tx <= 1'b0;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_nbyte    <= '0;
            tx_msg      <= '0;
        end else begin
            uart_tx     <= tx_line;
            flag_end_tx <= tx_last;
            if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
            else                                tx_cnt <= tx_cnt + 1'b1;
            unique case (tx_state)
                TX_IDLE: begin
                    if (send_uart) begin
                        tx_msg   <= send_msg;
                        tx_nbyte <= '0;
                        tx_bit   <= '0;
                    end
                end
                TX_DATA: if (tx_tick) tx_bit <= tx_bit + 1'b1;
                TX_STOP: begin
                    if (tx_tick) begin
                        tx_nbyte <= tx_nbyte + 1'b1;
                        tx_msg   <= tx_msg << 8;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed bench for uart_cmd_link: packet vector table plus TX, false-start and reset sequences.
module tb_uart_cmd_link;

    localparam int DIV = 65;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic        uart_tx;
    logic        send_uart;
    logic [15:0] send_msg;
    logic        tx_busy, flag_end_tx;
    logic [7:0]  trigger;
    logic [12:0] threshold;
    logic [23:0] samples_after, samples_before;
    logic        flag_acq, flag_debug, rx_error;

    uart_cmd_link #(
        .CLK_HZ(60_000_000),
        .BAUD(921600),
        .TX_BYTES(2),
        .RX_TIMEOUT_BITS(20)
    ) dut (
        .clk_PSRAM(clk),
        .rst_n(rst_n),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .send_uart(send_uart),
        .send_msg(send_msg),
        .tx_busy(tx_busy),
        .flag_end_tx(flag_end_tx),
        .trigger(trigger),
        .threshold(threshold),
        .samples_after(samples_after),
        .samples_before(samples_before),
        .flag_acq(flag_acq),
        .flag_debug(flag_debug),
        .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int acq_cnt = 0, dbg_cnt = 0, err_cnt = 0, end_cnt = 0, busy_cyc = 0, ovl_cnt = 0;
    int last_err_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (flag_acq)    acq_cnt++;
        if (flag_debug)  dbg_cnt++;
        if (rx_error) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (flag_end_tx) end_cnt++;
        if (tx_busy)     busy_cyc++;
        if (flag_end_tx && tx_busy) ovl_cnt++;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = good_stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic get_tx_byte(output logic [7:0] b, output logic start_v, output logic stop_v,
                               output bit found);
        found   = 1'b0;
        b       = '0;
        start_v = 1'b1;
        stop_v  = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) found = 1'b1;
        end
        if (!found) return;
        repeat (DIV / 2) @(negedge clk);
        start_v = uart_tx;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        stop_v = uart_tx;
    endtask

    typedef struct packed {
        logic [87:0] b;
        int          n;
        int          bad;
        int          idle;
        bit          timed;
        int          acq;
        int          dbg;
        int          err;
        logic [7:0]  trig;
        logic [12:0] thr;
        logic [23:0] aft;
        logic [23:0] bef;
    } vec_t;

    function automatic vec_t mk(input logic [87:0] b, input int n, input int bad, input int idle,
                                input bit timed, input int acq, input int dbg, input int err,
                                input logic [7:0] tg, input logic [12:0] th,
                                input logic [23:0] af, input logic [23:0] bf);
        vec_t v;
        v.b = b; v.n = n; v.bad = bad; v.idle = idle; v.timed = timed;
        v.acq = acq; v.dbg = dbg; v.err = err;
        v.trig = tg; v.thr = th; v.aft = af; v.bef = bf;
        return v;
    endfunction

    vec_t tbl[8];
    vec_t v;
    int   a0, d0, e0, c0, end_cyc, gap;
    logic [7:0] rb0, rb1;
    logic sv0, sv1, tv0, tv1;
    bit   f0, f1;

    initial begin
        tbl[0] = mk(88'h41_54_01_F4_00_10_00_00_00_20_00, 10, -1, 3, 0, 1, 0, 0,
                    8'h54, 13'h01F4, 24'h001000, 24'h000020);
        tbl[1] = mk(88'h53_00_00_00_00_00_00_00_00_00_00, 1, -1, 3, 0, 0, 1, 0,
                    8'h54, 13'h01F4, 24'h001000, 24'h000020);
        tbl[2] = mk(88'h41_53_02_34_12_34_56_AB_CD_EF_00, 10, -1, 3, 0, 1, 0, 0,
                    8'h53, 13'h0234, 24'h123456, 24'hABCDEF);
        tbl[3] = mk(88'h41_11_22_33_44_00_00_00_00_00_00, 5, 4, 3, 0, 0, 0, 1,
                    8'h53, 13'h0234, 24'h123456, 24'hABCDEF);
        tbl[4] = mk(88'h41_FF_E5_80_00_00_01_02_03_04_00, 10, -1, 3, 0, 1, 0, 0,
                    8'hFF, 13'h0580, 24'h000001, 24'h020304);
        tbl[5] = mk(88'h41_AA_BB_CC_DD_00_00_00_00_00_00, 5, -1, 25, 1, 0, 0, 1,
                    8'hFF, 13'h0580, 24'h000001, 24'h020304);
        tbl[6] = mk(88'h41_00_00_00_00_00_00_FF_FF_FF_00, 10, -1, 3, 0, 1, 0, 0,
                    8'h00, 13'h0000, 24'h000000, 24'hFFFFFF);
        tbl[7] = mk(88'h12_41_01_1F_FF_7F_FF_FF_80_00_00, 11, -1, 3, 0, 1, 0, 0,
                    8'h01, 13'h1FFF, 24'h7FFFFF, 24'h800000);

        rst_n = 1'b0; uart_rx = 1'b1; send_uart = 1'b0; send_msg = '0;
        repeat (5) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_trigger", trigger, 0);
        chk("rst_threshold", threshold, 0);
        chk("rst_after", samples_after, 0);
        chk("rst_before", samples_before, 0);
        chk("rst_flags", {flag_acq, flag_debug, rx_error, flag_end_tx}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            v  = tbl[k];
            a0 = acq_cnt; d0 = dbg_cnt; e0 = err_cnt;
            for (int i = 0; i < v.n; i++)
                send_byte(v.b[87-8*i -: 8], (i != v.bad));
            end_cyc = cyc;
            repeat (v.idle * DIV) @(negedge clk);
            chk($sformatf("v%0d_acq_pulses", k), acq_cnt - a0, v.acq);
            chk($sformatf("v%0d_dbg_pulses", k), dbg_cnt - d0, v.dbg);
            chk($sformatf("v%0d_err_pulses", k), err_cnt - e0, v.err);
            chk($sformatf("v%0d_trigger", k), trigger, v.trig);
            chk($sformatf("v%0d_threshold", k), threshold, v.thr);
            chk($sformatf("v%0d_after", k), samples_after, v.aft);
            chk($sformatf("v%0d_before", k), samples_before, v.bef);
            if (v.timed) begin
                // Stop sample sits ~31 cycles before the end of the driven stop bit.
                gap = last_err_cyc - end_cyc;
                n_vec++;
                if (gap < 1255 || gap > 1285) begin
                    n_bad++;
                    $display("FAIL v%0d_timeout_time: gap %0d cycles, required 1255..1285", k, gap);
                end
            end
        end

        // False start: 20 low cycles is shorter than the half-bit recheck.
        a0 = acq_cnt; d0 = dbg_cnt; e0 = err_cnt;
        uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("false_start_err", err_cnt - e0, 0);
        send_byte(8'h53, 1'b1);
        repeat (3 * DIV) @(negedge clk);
        chk("after_false_dbg", dbg_cnt - d0, 1);
        chk("after_false_err", err_cnt - e0, 0);
        chk("after_false_acq", acq_cnt - a0, 0);

        // TX frame with an extra request mid-frame that must be ignored.
        c0 = busy_cyc; a0 = end_cnt;
        send_msg  = 16'hA55A;
        send_uart = 1'b1;
        @(negedge clk);
        send_uart = 1'b0;
        chk("tx_busy_start", tx_busy, 1);
        fork
            begin
                get_tx_byte(rb0, sv0, tv0, f0);
                get_tx_byte(rb1, sv1, tv1, f1);
            end
            begin
                repeat (500) @(negedge clk);
                send_msg  = 16'h1234;
                send_uart = 1'b1;
                @(negedge clk);
                send_uart = 1'b0;
            end
        join
        chk("tx_found0", f0, 1);
        chk("tx_found1", f1, 1);
        chk("tx_byte0", rb0, 8'hA5);
        chk("tx_byte1", rb1, 8'h5A);
        chk("tx_start_bits", {sv0, sv1}, 2'b00);
        chk("tx_stop_bits", {tv0, tv1}, 2'b11);
        repeat (1500) @(negedge clk);
        chk("tx_busy_cycles", busy_cyc - c0, 1300);
        chk("tx_end_pulses", end_cnt - a0, 1);
        chk("tx_end_busy_overlap", ovl_cnt, 0);
        chk("tx_idle_busy", tx_busy, 0);
        chk("tx_idle_line", uart_tx, 1);

        // Reset during a start bit.
        a0 = end_cnt;
        send_msg  = 16'h0F0F;
        send_uart = 1'b1;
        @(negedge clk);
        send_uart = 1'b0;
        repeat (20) @(negedge clk);
        chk("midtx_line_low", uart_tx, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_uart_tx", uart_tx, 1);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_trigger", trigger, 0);
        chk("midrst_config", {threshold, samples_after, samples_before} == '0, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1500) @(negedge clk);
        chk("midrst_no_end", end_cnt - a0, 0);
        chk("midrst_line_idle", uart_tx, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
